// File: rtl/rgb_pkg.sv
// Shared types for the RGB hue fader: hue sector encoding and the wheel-step helper.
package rgb_pkg;

    typedef enum logic [2:0] {
        RED     = 3'd0,
        YELLOW  = 3'd1,
        GREEN   = 3'd2,
        CYAN    = 3'd3,
        BLUE    = 3'd4,
        MAGENTA = 3'd5
    } sector_t;

    // Unused encodings fall back to RED so a corrupted sector self-heals.
    function automatic sector_t next_sector(input sector_t cur);
        sector_t nxt;
        case (cur)
            RED:     nxt = YELLOW;
            YELLOW:  nxt = GREEN;
            GREEN:   nxt = CYAN;
            CYAN:    nxt = BLUE;
            BLUE:    nxt = MAGENTA;
            MAGENTA: nxt = RED;
            default: nxt = RED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel: duty latched at period end, registered polarity-adjusted pin.
module rgb_pwm_channel #(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] level,
    output logic                pin
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                pin_q;
    logic                pin_d;
    logic                lit_s;

    // Next duty and pin level; duty only moves on the last count of a period.
    always_comb begin
        duty_d = duty_q;
        if (pwm_cnt == MAX) begin
            duty_d = level;
        end else begin
            duty_d = duty_q;
        end
        lit_s = (duty_q == MAX) || (pwm_cnt < duty_q);
        pin_d = lit_s ^ ACTIVE_LOW;
    end

    // Duty latch and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= {PWM_BITS{1'b0}};
            pin_q  <= ACTIVE_LOW;
        end else begin
            duty_q <= duty_d;
            pin_q  <= pin_d;
        end
    end

    assign pin = pin_q;

endmodule

// File: rtl/rgb_hue_fader.sv
// Hue-wheel RGB LED driver: prescaled ramp walks six sectors, three PWM channels drive the pins.
module rgb_hue_fader
    import rgb_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int STEP_INTERVAL = 46_875,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] sector,
    output logic       wheel_wrap
);

    localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
    localparam int PRESC_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_INTERVAL - 1);

    logic [PRESC_W-1:0]  presc_q,   presc_d;
    logic [PWM_BITS-1:0] ramp_q,    ramp_d;
    sector_t             sector_q,  sector_d;
    logic                wrap_q,    wrap_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    logic                tick_s;
    logic [PWM_BITS-1:0] ramp_inv_s;
    logic [PWM_BITS-1:0] lvl_r_s, lvl_g_s, lvl_b_s;

    // Prescaler, ramp and sector advance; a paused run holds everything in place.
    always_comb begin
        tick_s    = run && (presc_q == PRESC_LAST);
        presc_d   = presc_q;
        ramp_d    = ramp_q;
        sector_d  = sector_q;
        wrap_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
        if (tick_s) begin
            presc_d = {PRESC_W{1'b0}};
            ramp_d  = ramp_q + {{(PWM_BITS-1){1'b0}}, 1'b1};
            if (ramp_q == MAX) begin
                sector_d = next_sector(sector_q);
                wrap_d   = (sector_q == MAGENTA);
            end else begin
                sector_d = sector_q;
                wrap_d   = 1'b0;
            end
        end else if (run) begin
            presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end else begin
            presc_d = presc_q;
        end
    end

    // Target level per channel; ramp_inv never underflows because ramp <= MAX.
    always_comb begin
        ramp_inv_s = MAX - ramp_q;
        lvl_r_s    = ZERO;
        lvl_g_s    = ZERO;
        lvl_b_s    = ZERO;
        if (mode) begin
            case (sector_q)
                RED:     begin lvl_r_s = MAX;        lvl_g_s = ramp_q;     lvl_b_s = ZERO;       end
                YELLOW:  begin lvl_r_s = ramp_inv_s; lvl_g_s = MAX;        lvl_b_s = ZERO;       end
                GREEN:   begin lvl_r_s = ZERO;       lvl_g_s = MAX;        lvl_b_s = ramp_q;     end
                CYAN:    begin lvl_r_s = ZERO;       lvl_g_s = ramp_inv_s; lvl_b_s = MAX;        end
                BLUE:    begin lvl_r_s = ramp_q;     lvl_g_s = ZERO;       lvl_b_s = MAX;        end
                MAGENTA: begin lvl_r_s = MAX;        lvl_g_s = ZERO;       lvl_b_s = ramp_inv_s; end
                default: begin lvl_r_s = ZERO;       lvl_g_s = ZERO;       lvl_b_s = ZERO;       end
            endcase
        end else begin
            case (sector_q)
                RED:     begin lvl_r_s = MAX;  lvl_g_s = ZERO; lvl_b_s = ZERO; end
                YELLOW:  begin lvl_r_s = MAX;  lvl_g_s = MAX;  lvl_b_s = ZERO; end
                GREEN:   begin lvl_r_s = ZERO; lvl_g_s = MAX;  lvl_b_s = ZERO; end
                CYAN:    begin lvl_r_s = ZERO; lvl_g_s = MAX;  lvl_b_s = MAX;  end
                BLUE:    begin lvl_r_s = ZERO; lvl_g_s = ZERO; lvl_b_s = MAX;  end
                MAGENTA: begin lvl_r_s = MAX;  lvl_g_s = ZERO; lvl_b_s = MAX;  end
                default: begin lvl_r_s = ZERO; lvl_g_s = ZERO; lvl_b_s = ZERO; end
            endcase
        end
    end

    // Hue state and free-running PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= {PRESC_W{1'b0}};
            ramp_q    <= ZERO;
            sector_q  <= RED;
            wrap_q    <= 1'b0;
            pwm_cnt_q <= ZERO;
        end else begin
            presc_q   <= presc_d;
            ramp_q    <= ramp_d;
            sector_q  <= sector_d;
            wrap_q    <= wrap_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_r (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt_q),
        .level   (lvl_r_s),
        .pin     (RGB_R)
    );

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_g (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt_q),
        .level   (lvl_g_s),
        .pin     (RGB_G)
    );

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_ch_b (
        .clk     (clk),
        .rst     (rst),
        .pwm_cnt (pwm_cnt_q),
        .level   (lvl_b_s),
        .pin     (RGB_B)
    );

    assign sector     = sector_q;
    assign wheel_wrap = wrap_q;

endmodule

// File: doc/rgb_hue_fader.md
Name: rgb_hue_fader

Overview:
- Parametrised successor to the fixed six-colour RGB LED stepper.
- Walks the same hue wheel: RED → YELLOW → GREEN → CYAN → BLUE → MAGENTA → RED.
- Adds per-channel PWM with selectable hard-step or smooth-fade mode, run/pause control, configurable PWM resolution, step rate and output polarity.
- Drives the board RGB LED pins directly from the 12 MHz system clock.

Parameters:
- PWM_BITS, 8, PWM/ramp resolution; MAX = 2^PWM_BITS-1.
- STEP_INTERVAL, 46_875, clk cycles per ramp step (full wheel ≈ 6·256·46_875 clk ≈ 6 s at 12 MHz).
- ACTIVE_LOW, 1, 1 = LED pins driven low when lit.

Ports:
- clk  in  1  system clock, 12 MHz
- rst  in  1  synchronous active-high reset
- run  in  1  1 = hue advances; 0 = hue frozen, PWM keeps running
- mode  in  1  0 = hard step (pure sector colours); 1 = smooth fade
- RGB_R  out  1  red LED pin, registered
- RGB_G  out  1  green LED pin, registered
- RGB_B  out  1  blue LED pin, registered
- sector  out  3  current hue sector (sector_t encoding)
- wheel_wrap  out  1  one-cycle pulse when sector advances MAGENTA → RED

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset (next posedge with rst=1, including mid-operation):
  - All internal state clears: prescaler=0, ramp=0, sector=RED, pwm_cnt=0, duty latches=0.
  - Outputs go to the unlit level (1 when ACTIVE_LOW=1); wheel_wrap=0.
- Prescaler:
  - Counts 0..STEP_INTERVAL-1 while run=1 and holds while run=0.
  - tick = run && prescaler==STEP_INTERVAL-1; on tick the prescaler returns to 0.
- Ramp:
  - On tick, ramp increments.
  - When ramp==MAX on a tick, ramp wraps to 0 and sector advances one step.
  - If the advance is MAGENTA → RED, wheel_wrap=1 for exactly that cycle.
  - An illegal sector value (6, 7) advances to RED.
- Target levels, mode=1 (fade):
  - RED: R=MAX, G=ramp, B=0
  - YELLOW: R=MAX-ramp, G=MAX, B=0
  - GREEN: R=0, G=MAX, B=ramp
  - CYAN: R=0, G=MAX-ramp, B=MAX
  - BLUE: R=ramp, G=0, B=MAX
  - MAGENTA: R=MAX, G=0, B=MAX-ramp
- Target levels, mode=0 (step): each component is MAX or 0 per pure sector colour.
  - RED: R
  - YELLOW: R+G
  - GREEN: G
  - CYAN: G+B
  - BLUE: B
  - MAGENTA: R+B
- PWM counter: pwm_cnt (PWM_BITS) free-runs every clk and wraps MAX → 0, independent of run.
- Duty latch:
  - Each channel's duty latches its target level only on the cycle pwm_cnt==MAX, taking effect for the period starting at pwm_cnt=0.
  - Mode or level changes therefore never glitch a period.
- Lit condition: lit = (duty==MAX) || (pwm_cnt < duty).
  - duty=0 → never lit; duty=MAX → lit all period.
- Output stage:
  - Pin = lit XOR ACTIVE_LOW, registered.
  - One clk latency from pwm_cnt to pin.
- Simultaneous events: rst has priority over tick and latch; run falling on a tick cycle suppresses that tick.
- Widths: level arithmetic is PWM_BITS unsigned; MAX-ramp never underflows since ramp ≤ MAX.

Decomposition:
- Package rgb_pkg holds:
  - sector_t: 3-bit enum, RED=0, YELLOW=1, GREEN=2, CYAN=3, BLUE=4, MAGENTA=5.
  - Function next_sector().
- One sub-module, rgb_pwm_channel (param PWM_BITS, ACTIVE_LOW):
  - Inputs: clk, rst, pwm_cnt, level.
  - Contains the duty latch and output register.
  - Instantiated three times.
- Top holds the prescaler, ramp, sector FSM, level mux and pwm_cnt.

Test Plan:
(All scenarios use PWM_BITS=3, STEP_INTERVAL=4, ACTIVE_LOW=1 unless noted.)
1. Reset: rst=1 for 3 clk, then 0, run=1 → pins {R,G,B}=111 during and on release; sector=0; first tick occurs on the 4th clk after release.
2. Step mode, run=1 → sector changes every 32 clk through 0,1,2,3,4,5,0; wheel_wrap pulses once per 192 clk. Steady pins per period, {R,G,B} by sector:
   - RED: 011
   - YELLOW: 001
   - GREEN: 101
   - CYAN: 100
   - BLUE: 110
   - MAGENTA: 010
3. Fade mode, sector RED, ramp=3 latched → over one 8-clk PWM period: RGB_R low 8/8, RGB_G low exactly 3/8 (pwm_cnt 0-2, pin one clk later), RGB_B high 8/8.
4. Pause: drop run for 100 clk mid-sector → ramp, sector and prescaler unchanged; PWM duty pattern continues identically; advance resumes on release with prescaler value preserved.
5. Mode switch 0→1 at pwm_cnt=2 → current period unchanged; new duty applied from the next pwm_cnt=0.
6. Reset during fade (sector=CYAN, ramp=5) → pins 111 on the next clk; sector=RED, ramp=0; ACTIVE_LOW=0 rerun gives pins 000.
